// File: rtl/reset_req_pulser_pkg.sv
// rtl/reset_req_pulser_pkg.sv - shared FSM state, channel limit and stats width for the reset pulser
package reset_req_pulser_pkg;

  localparam int MAX_CH  = 8;
  localparam int STATS_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Isolates the lowest set bit, i.e. the highest-priority request.
  function automatic logic [MAX_CH-1:0] lowest_one(input logic [MAX_CH-1:0] v);
    return v & (~v + MAX_CH'(1));
  endfunction

endpackage

// File: rtl/reset_req_pulser_if.sv
// rtl/reset_req_pulser_if.sv - request/pulse bundle for reset_req_pulser
// Optional poulCount member present when RESET_REQ_PULSER_STATS_EN is defined.
interface reset_req_pulser_if
  import reset_req_pulser_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 6
);
  logic [NUM_CH-1:0]            piulReq;
  logic [NUM_CH-1:0][CNT_W-1:0] piulLen;
  logic                         piul1Enable;
  logic [NUM_CH-1:0]            poulPulse;
  logic                         poul1Busy;
  logic [NUM_CH-1:0]            poulDropped;
`ifdef RESET_REQ_PULSER_STATS_EN
  logic [NUM_CH-1:0][STATS_W-1:0] poulCount;
`endif

  modport master (
    output piulReq, piulLen, piul1Enable,
`ifdef RESET_REQ_PULSER_STATS_EN
    input  poulCount,
`endif
    input  poulPulse, poul1Busy, poulDropped
  );

  modport slave (
    input  piulReq, piulLen, piul1Enable,
`ifdef RESET_REQ_PULSER_STATS_EN
    output poulCount,
`endif
    output poulPulse, poul1Busy, poulDropped
  );

endinterface

// File: rtl/reset_req_edge_sync.sv
// rtl/reset_req_edge_sync.sv - one-channel synchroniser plus registered edge detector
module reset_req_edge_sync #(
  parameter bit RISE   = 1'b1,
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  output logic edge_o
);

  // Idle level of the channel, so reset never manufactures an edge.
  localparam logic INACT = ~RISE;

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              edge_q;
  logic              lvl;

  assign lvl = sync_q[STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{INACT}};
      prev_q <= INACT;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], req_i};
      prev_q <= lvl;
      edge_q <= RISE ? (lvl & ~prev_q) : (~lvl & prev_q);
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/reset_req_pulser.sv
// rtl/reset_req_pulser.sv - prioritised reset-request pulse generator
// Per-channel pulse counters added when RESET_REQ_PULSER_STATS_EN is defined.
module reset_req_pulser
  import reset_req_pulser_pkg::*;
#(
  parameter int                NUM_CH      = 3,
  parameter int                CNT_W       = 6,
  parameter logic [NUM_CH-1:0] EDGE_RISE   = '1,
  parameter int                IGNORE_BUSY = 1,
  parameter int                SYNC_STAGES = 2
) (
  input  logic               piul1Clock,
  input  logic               piul1Reset,
  reset_req_pulser_if.slave  bus
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NUM_CH-1:0] edge_w, trig_q, pend_q, drop_q, act_q, pulse_q;
  logic              busy_q;

  logic [NUM_CH-1:0] req_all, win_idle, hi_trig, win_hi, pend_busy;
  logic [CNT_W-1:0]  len_sel, len_eff;
  logic              start;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    reset_req_edge_sync #(
      .RISE   (EDGE_RISE[g]),
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk_i  (piul1Clock),
      .rst_i  (piul1Reset),
      .req_i  (bus.piulReq[g]),
      .edge_o (edge_w[g])
    );
  end

  always_comb begin
    req_all  = pend_q | trig_q;
    win_idle = NUM_CH'(lowest_one(MAX_CH'(req_all)));
    // act_q is one-hot, so act_q-1 masks exactly the higher-priority channels.
    hi_trig  = trig_q & (act_q - NUM_CH'(1));
    win_hi   = NUM_CH'(lowest_one(MAX_CH'(hi_trig)));
    pend_busy = (IGNORE_BUSY != 0) ? pend_q : (pend_q | trig_q);
    len_sel  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_idle[i]) len_sel = bus.piulLen[i];
    end
    len_eff  = (len_sel == '0) ? CNT_W'(1) : len_sel;
    start    = (state_q != ST_PULSE) && (|req_all);
  end

  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      trig_q  <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
      act_q   <= '0;
      pulse_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      trig_q <= edge_w & {NUM_CH{bus.piul1Enable}};
      case (state_q)
        ST_IDLE, ST_GAP: begin
          if (|req_all) begin
            state_q <= ST_PULSE;
            act_q   <= win_idle;
            pulse_q <= win_idle;
            cnt_q   <= len_eff;
            busy_q  <= 1'b1;
            if (IGNORE_BUSY != 0) begin
              pend_q <= pend_q & ~win_idle;
              drop_q <= drop_q | (trig_q & ~win_idle);
            end else begin
              pend_q <= req_all & ~win_idle;
            end
          end else begin
            state_q <= ST_IDLE;
            act_q   <= '0;
            pulse_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        ST_PULSE: begin
          if (|hi_trig) begin
            // Preemption: the winner is always remembered, even when busy triggers are dropped.
            state_q <= ST_GAP;
            act_q   <= '0;
            pulse_q <= '0;
            busy_q  <= 1'b1;
            if (IGNORE_BUSY != 0) begin
              pend_q <= pend_q | win_hi;
              drop_q <= drop_q | (trig_q & ~win_hi);
            end else begin
              pend_q <= pend_q | trig_q;
            end
          end else begin
            if (IGNORE_BUSY != 0) drop_q <= drop_q | trig_q;
            else                  pend_q <= pend_q | trig_q;
            if (cnt_q <= CNT_W'(1)) begin
              state_q <= ST_GAP;
              act_q   <= '0;
              pulse_q <= '0;
              busy_q  <= |pend_busy;
            end else begin
              cnt_q   <= cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          act_q   <= '0;
          pulse_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.poulPulse   = pulse_q;
  assign bus.poul1Busy   = busy_q;
  assign bus.poulDropped = drop_q;

`ifdef RESET_REQ_PULSER_STATS_EN
  logic [NUM_CH-1:0][STATS_W-1:0] count_q;

  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (start && win_idle[i] && (count_q[i] != '1)) count_q[i] <= count_q[i] + STATS_W'(1);
      end
    end
  end

  assign bus.poulCount = count_q;
`else
  logic unused_start;
  assign unused_start = start;
`endif

endmodule
